// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Multi-cycle signed multiplier built on radix-4 (modified) Booth recoding.
// A start pulse captures two WIDTH-bit two's-complement operands. The block
// then retires one Booth digit per clock and returns the full 2*WIDTH-bit
// signed product after WIDTH/2 cycles. The result is held, flagged by
// ready, until the next accepted start or a reset.
//
// Parameters
//   WIDTH         operand width in bits (even, >= 4)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous reset, active HIGH (the name is historical)
//   start         start request, honoured only in idle/done
//   multiplicand  operand A, signed
//   multiplier    operand B, signed
//   ready         product holds a completed result
//   product       signed A*B, registered
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned Steps = WIDTH / 2;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam int unsigned AccW  = 2 * WIDTH + 2;
    localparam int unsigned PpW   = WIDTH + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Datapath registers
    logic [WIDTH-1:0]   a_q;       // captured multiplicand
    logic [WIDTH:0]     b_q;       // {multiplier, 0}; low three bits are the current triplet
    logic [AccW-1:0]    acc_q;     // running sum, wide enough for -2A at the extreme
    logic [CntW-1:0]    cnt_q;     // Booth step index i
    logic [2*WIDTH-1:0] product_q;
    logic               ready_q;

    // Control strobes from the FSM
    logic load;
    logic step;
    logic finish;
    logic last_step;

    // Booth datapath
    logic [PpW-1:0]   a_ext;
    logic [PpW-1:0]   pp_mag;
    logic             pp_neg;
    logic [PpW-1:0]   pp;
    logic [AccW-1:0]  pp_wide;
    logic [CntW:0]    shamt;
    logic [AccW-1:0]  pp_shift;
    logic [AccW-1:0]  acc_d;
    logic [WIDTH:0]   b_d;

    assign last_step = (cnt_q == LastCnt);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // start is deliberately not looked at here
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StBusy;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                load = start;
            end
            StBusy: begin
                step   = 1'b1;
                finish = last_step;
            end
            default: begin
                load   = 1'b0;
                step   = 1'b0;
                finish = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Booth recoding of the current triplet {b[2i+1], b[2i], b[2i-1]}
    // -----------------------------------------------------------------------
    assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};

    always_comb begin
        pp_mag = '0;
        pp_neg = 1'b0;
        unique case (b_q[2:0])
            3'b000, 3'b111: begin
                pp_mag = '0;
                pp_neg = 1'b0;
            end
            3'b001, 3'b010: begin
                pp_mag = a_ext;
                pp_neg = 1'b0;
            end
            3'b011: begin
                pp_mag = a_ext << 1;
                pp_neg = 1'b0;
            end
            3'b100: begin
                pp_mag = a_ext << 1;
                pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_mag = a_ext;
                pp_neg = 1'b1;
            end
            default: begin
                pp_mag = '0;
                pp_neg = 1'b0;
            end
        endcase
    end

    // Two guard bits keep +2^WIDTH (from -2A with A = -2^(WIDTH-1)) representable.
    assign pp       = pp_neg ? (~pp_mag + 1'b1) : pp_mag;
    assign pp_wide  = {{WIDTH{pp[PpW-1]}}, pp};
    assign shamt    = {cnt_q, 1'b0};
    assign pp_shift = pp_wide << shamt;
    assign acc_d    = acc_q + pp_shift;

    // Move the next triplet into b_q[2:0]; zero fill is never examined.
    assign b_d = {2'b00, b_q[WIDTH:2]};

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b0;
        end else if (load) begin
            a_q     <= multiplicand;
            b_q     <= {multiplier, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (step) begin
            acc_q <= acc_d;
            b_q   <= b_d;
            cnt_q <= cnt_q + 1'b1;
            if (finish) begin
                // Take the sum including this final step, not the stale acc_q.
                product_q <= acc_d[2*WIDTH-1:0];
                ready_q   <= 1'b1;
            end
        end
    end

    assign ready   = ready_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed bench for seq_multiplier at WIDTH=16. Each operation is checked
// for exact latency (ready low on edges 0..7, high on edge 8), for product
// holding its old value while busy, and for the final product value.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int unsigned W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           ready;
    logic [2*W-1:0] product;

    int checks;
    int errors;

    seq_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .ready       (ready),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; hold_edges > 0 re-checks the result later on.
    task automatic do_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input logic signed [31:0] exp, input string tag,
                         input int hold_edges);
        logic [31:0] prev;
        @(negedge clk);
        prev         = product;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        check({tag, " ready_edge0"}, 32'(ready), 32'd0);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            check({tag, " ready_busy"}, 32'(ready), 32'd0);
            check({tag, " product_busy"}, product, prev);
        end
        @(posedge clk);
        #1;
        check({tag, " ready_edge8"}, 32'(ready), 32'd1);
        check({tag, " product"}, product, exp);
        if (hold_edges > 0) begin
            repeat (hold_edges) @(posedge clk);
            #1;
            check({tag, " ready_hold"}, 32'(ready), 32'd1);
            check({tag, " product_hold"}, product, exp);
        end
    endtask

    initial begin
        logic signed [W-1:0]  ra;
        logic signed [W-1:0]  rb;
        logic signed [31:0]   ea;
        logic signed [31:0]   eb;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 32'(ready), 32'd0);
        check("rst product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("idle ready", 32'(ready), 32'd0);

        // Zero operands
        do_op(16'sd0,      16'sd0, 32'sd0, "0x0", 0);
        do_op(16'sd32767,  16'sd0, 32'sd0, "max x 0", 0);
        do_op(-16'sd32768, 16'sd0, 32'sd0, "min x 0", 0);

        // Unit and sign cases
        do_op(16'sd1,     16'sd1,     32'sd1,      "1x1", 0);
        do_op(16'sd32767, 16'sd1,     32'sd32767,  "max x 1", 0);
        do_op(16'sd1,     16'sd32767, 32'sd32767,  "1 x max", 0);
        do_op(-16'sd1,    -16'sd1,    32'sd1,      "-1x-1", 0);
        do_op(16'sd32767, -16'sd1,    -32'sd32767, "max x -1", 0);
        do_op(-16'sd1,    16'sd32767, -32'sd32767, "-1 x max", 0);

        // Corners
        do_op(16'sd32767,  16'sd32767,  32'sd1073676289,  "max x max", 8);
        do_op(16'sd32767,  -16'sd32768, -32'sd1073709056, "max x min", 8);
        do_op(-16'sd32768, -16'sd32768, 32'sd1073741824,  "min x min", 8);
        do_op(-16'sd32768, 16'sd2,      -32'sd65536,      "min x 2", 0);
        do_op(16'sd3,      -16'sd5,     -32'sd15,         "3 x -5", 0);

        // Sweep A=i, B=i+10 (strided) interleaved with random pairs
        for (int i = 0; i < 50000; i += 1999) begin
            ra = 16'(i);
            rb = 16'(i + 10);
            ea = ra;
            eb = rb;
            do_op(ra, rb, ea * eb, "sweep", 8);
            ra = 16'($urandom);
            rb = 16'($urandom);
            ea = ra;
            eb = rb;
            do_op(ra, rb, ea * eb, "random", 0);
        end

        // start held through BUSY is ignored; accepted on the first DONE edge
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'sd300;
        multiplier   = -16'sd5;
        @(posedge clk);
        #1;
        multiplicand = -16'sd1000;
        multiplier   = 16'sd123;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("b2b ready_busy", 32'(ready), 32'd0);
        end
        @(posedge clk);
        #1;
        check("b2b ready_first", 32'(ready), 32'd1);
        check("b2b product_first", product, -32'sd1500);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b ready_restart", 32'(ready), 32'd0);
        check("b2b product_kept", product, -32'sd1500);
        repeat (7) @(posedge clk);
        #1;
        check("b2b ready_second_early", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        check("b2b ready_second", 32'(ready), 32'd1);
        check("b2b product_second", product, -32'sd123000);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'sd1234;
        multiplier   = 16'sd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("mid rst ready", 32'(ready), 32'd0);
        check("mid rst product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post rst ready", 32'(ready), 32'd0);
        check("post rst product", product, 32'd0);
        do_op(-16'sd7, 16'sd9, -32'sd63, "-7x9", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
